am2940_ctrl: RTL and testbench
==============================

# am2940_ctrl

Control unit for the Am2940 DMA address generator datapath (3-bit control register, 8-bit address/word registers, 8-bit address/word counters, 2:1 load muxes). Decodes the 3-bit instruction, holds the control register and transfer state, and drives load, increment, decrement and enable strobes for the counters plus the output-select code. It sits between the microprogram sequencer (Am2910 side) and the datapath.

## Interface
- W, 8, width of address/word counters and registers
- clk  in  1  rising-edge clock
- res  in  1  asynchronous, active-low reset
- ien  in  1  instruction enable; 0 = NOP
- instr  in  3  opcode
- di  in  W  data bus; di[2:0] written to CR
- wc_val  in  W  current word-counter value
- wr_val  in  W  word-register value
- cr  out  3  control register
- ar_pl, wr_pl  out  1  load address/word register from di
- ac_pl, wc_pl  out  1  parallel-load address/word counter
- ac_src, wc_src  out  1  counter load mux select: 0 = di, 1 = register
- wc_res  out  1  clear word counter to 0
- ac_en, ac_inc, ac_dec  out  1  address counter step controls
- wc_en, wc_inc, wc_dec  out  1  word counter step controls
- oe_sel  out  2  00 none, 01 CR, 10 WC, 11 AC
- done  out  1  transfer complete (registered)
- busy  out  1  state == ARMED

## Operation
- Opcodes: 0 WRCR, 1 RDCR, 2 RDWC, 3 RDAC, 4 REINIT, 5 LDADDR, 6 LDWC, 7 ENABLE.
- CR[1:0] word mode: 00 WC decrement, terminal when wc_val == 1; 01 WC increment, terminal when (wc_val + 1) mod 2^W == wr_val; 10 WC increment, terminal when wc_val == all ones; 11 WC held (wc_en = 0), never terminal.
- CR[2]: 0 address increment, 1 address decrement.
- States: IDLE (reset), ARMED, DONE.
- WRCR: cr <= di[2:0]; state unchanged.
- RDCR/RDWC/RDAC: oe_sel = 01/10/11; no state change. oe_sel = 00 for all other opcodes.
- LDADDR: ar_pl = ac_pl = 1, ac_src = 0; state unchanged.
- LDWC: wr_pl = wc_pl = 1, wc_src = 0; done <= 0; state -> ARMED.
- REINIT: ac_pl = 1, ac_src = 1; mode 01: wc_res = 1; other modes: wc_pl = 1, wc_src = 1; done <= 0; state -> ARMED.
- ENABLE in ARMED: ac_en = 1 with ac_inc/ac_dec per CR[2]; wc_en = 1 with wc_inc/wc_dec per mode (mode 11: wc_en = 0). If terminal: done <= 1, state -> DONE.
- ENABLE in IDLE or DONE: all strobes 0 (counting inhibited).
- ien = 0: all strobes 0, oe_sel = 00, no state change.
- Only one of inc/dec is asserted per counter, and only when that counter's en = 1.

## Timing
- Strobes and oe_sel are combinational (Mealy) from instr, ien, state, cr, wc_val, wr_val. The datapath captures them at the next rising edge.
- cr, state, and done update at the rising edge. done rises one cycle after the terminal ENABLE, alongside the counters' final step.
- Reset (res = 0, any time, including mid-transfer): state = IDLE, cr = 000, done = 0, all strobes and oe_sel forced to 0 while res = 0.
- A WRCR issued in ARMED changes the mode from the next cycle. The terminal test always uses the registered cr.
- Terminal arithmetic is W-bit, modulo 2^W. In mode 01 with wr_val == 0, the terminal is wc_val == all ones.

## Structure
- Package am2940_pkg holds:
  - opcode constants
  - word-mode encodings
  - oe_sel codes
  - state enum (IDLE, ARMED, DONE)
- Sub-module am2940_term: combinational terminal-count detector (inputs cr[1:0], wc_val, wr_val; output term).
- Top-level am2940_ctrl holds the CR, the state register, the done register and the strobe decoder.

## Test plan
- Reset: drive res = 0 mid-ARMED, then release -> cr = 000, done = 0, busy = 0, all strobes 0; ENABLE then gives no ac_en.
- Mode 00: WRCR di = 8'h00; LDWC di = 8'h03; three ENABLEs -> wc_dec pulses for wc_val 3, 2, 1; done = 1 the cycle after the third; a fourth ENABLE gives no strobes.
- Mode 01: WRCR 8'h01; LDWC 8'h02; REINIT -> wc_res = 1; ENABLE at wc_val 0, then 1 -> done after the second; CR[2] = 0 gives ac_inc.
- Mode 10 wrap: WRCR 8'h06; ENABLE at wc_val = 8'hfe, then 8'hff -> done after 8'hff; ac_dec asserted (CR[2] = 1).
- Mode 11: WRCR 8'h03; LDWC; 20 ENABLEs -> wc_en = 0 throughout, ac_en = 1 each cycle, done stays 0.
- Reads/NOP: RDCR/RDWC/RDAC -> oe_sel 01/10/11; ien = 0 with instr = 7 -> oe_sel 00, no strobes, state unchanged.

Source files
------------

// File: rtl/am2940_pkg.sv
// Shared encodings for the Am2940 DMA address generator control unit:
// opcodes, word-count modes, output-select codes and the transfer state.
package am2940_pkg;

  localparam logic [2:0] OP_WRCR   = 3'd0;
  localparam logic [2:0] OP_RDCR   = 3'd1;
  localparam logic [2:0] OP_RDWC   = 3'd2;
  localparam logic [2:0] OP_RDAC   = 3'd3;
  localparam logic [2:0] OP_REINIT = 3'd4;
  localparam logic [2:0] OP_LDADDR = 3'd5;
  localparam logic [2:0] OP_LDWC   = 3'd6;
  localparam logic [2:0] OP_ENABLE = 3'd7;

  localparam logic [1:0] WM_DEC_TO_ONE = 2'b00;
  localparam logic [1:0] WM_INC_TO_REG = 2'b01;
  localparam logic [1:0] WM_INC_TO_MAX = 2'b10;
  localparam logic [1:0] WM_HOLD       = 2'b11;

  localparam logic [1:0] OE_NONE = 2'b00;
  localparam logic [1:0] OE_CR   = 2'b01;
  localparam logic [1:0] OE_WC   = 2'b10;
  localparam logic [1:0] OE_AC   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/am2940_term.sv
// Terminal-count detector for the word counter, selected by the word mode.
module am2940_term
  import am2940_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   mode_i,
  input  logic [W-1:0] wc_val_i,
  input  logic [W-1:0] wr_val_i,
  output logic         term_o
);

  logic [W-1:0] wcNext;

  // The W-bit wrap makes wr_val == 0 terminate at wc_val == all ones.
  assign wcNext = wc_val_i + W'(1);

  always_comb begin
    term_o = 1'b0;
    case (mode_i)
      WM_DEC_TO_ONE: term_o = (wc_val_i == W'(1));
      WM_INC_TO_REG: term_o = (wcNext == wr_val_i);
      WM_INC_TO_MAX: term_o = (wc_val_i == {W{1'b1}});
      default:       term_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/am2940_ctrl.sv
// Am2940 control unit: instruction decode, control register, transfer
// state and the Mealy strobe decoder driving the address/word datapath.
module am2940_ctrl
  import am2940_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         ien,
  input  logic [2:0]   instr,
  input  logic [W-1:0] di,
  input  logic [W-1:0] wc_val,
  input  logic [W-1:0] wr_val,
  output logic [2:0]   cr,
  output logic         ar_pl,
  output logic         wr_pl,
  output logic         ac_pl,
  output logic         wc_pl,
  output logic         ac_src,
  output logic         wc_src,
  output logic         wc_res,
  output logic         ac_en,
  output logic         ac_inc,
  output logic         ac_dec,
  output logic         wc_en,
  output logic         wc_inc,
  output logic         wc_dec,
  output logic [1:0]   oe_sel,
  output logic         done,
  output logic         busy
);

  logic [2:0] cr_q, cr_d;
  state_e     state_q, state_d;
  logic       done_q, done_d;
  logic       term;
  logic       armed;

  am2940_term #(.W(W)) u_term (
    .mode_i   (cr_q[1:0]),
    .wc_val_i (wc_val),
    .wr_val_i (wr_val),
    .term_o   (term)
  );

  assign armed = (state_q == ST_ARMED);

  always_comb begin
    cr_d    = cr_q;
    state_d = state_q;
    done_d  = done_q;
    if (ien) begin
      case (instr)
        OP_WRCR: cr_d = di[2:0];
        OP_LDWC, OP_REINIT: begin
          done_d  = 1'b0;
          state_d = ST_ARMED;
        end
        OP_ENABLE: begin
          if (armed && term) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cr_q    <= 3'b000;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      cr_q    <= cr_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Strobes are held low while reset is asserted, not just after it.
  always_comb begin
    ar_pl  = 1'b0;
    wr_pl  = 1'b0;
    ac_pl  = 1'b0;
    wc_pl  = 1'b0;
    ac_src = 1'b0;
    wc_src = 1'b0;
    wc_res = 1'b0;
    ac_en  = 1'b0;
    ac_inc = 1'b0;
    ac_dec = 1'b0;
    wc_en  = 1'b0;
    wc_inc = 1'b0;
    wc_dec = 1'b0;
    oe_sel = OE_NONE;
    if (res && ien) begin
      case (instr)
        OP_RDCR: oe_sel = OE_CR;
        OP_RDWC: oe_sel = OE_WC;
        OP_RDAC: oe_sel = OE_AC;
        OP_LDADDR: begin
          ar_pl = 1'b1;
          ac_pl = 1'b1;
        end
        OP_LDWC: begin
          wr_pl = 1'b1;
          wc_pl = 1'b1;
        end
        OP_REINIT: begin
          ac_pl  = 1'b1;
          ac_src = 1'b1;
          if (cr_q[1:0] == WM_INC_TO_REG) begin
            wc_res = 1'b1;
          end else begin
            wc_pl  = 1'b1;
            wc_src = 1'b1;
          end
        end
        OP_ENABLE: begin
          if (armed) begin
            ac_en  = 1'b1;
            ac_inc = ~cr_q[2];
            ac_dec = cr_q[2];
            case (cr_q[1:0])
              WM_DEC_TO_ONE: begin
                wc_en  = 1'b1;
                wc_dec = 1'b1;
              end
              WM_INC_TO_REG, WM_INC_TO_MAX: begin
                wc_en  = 1'b1;
                wc_inc = 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign cr   = cr_q;
  assign done = done_q;
  assign busy = armed;

endmodule

// File: tb/tb_am2940_ctrl.sv
// Scoreboard bench for am2940_ctrl: directed vectors push hand-computed
// output snapshots; a negedge monitor pops and compares them.
module tb_am2940_ctrl;

  logic       clk;
  logic       res;
  logic       ien;
  logic [2:0] instr;
  logic [7:0] di;
  logic [7:0] wcVal;
  logic [7:0] wrVal;
  logic [2:0] cr;
  logic       arPl, wrPl, acPl, wcPl, acSrc, wcSrc, wcRes;
  logic       acEn, acInc, acDec, wcEn, wcInc, wcDec;
  logic [1:0] oeSel;
  logic       done;
  logic       busy;

  // Snapshot layout: {cr, load[6:0], step[5:0], oe_sel, done, busy}
  // load = {ar_pl, wr_pl, ac_pl, wc_pl, ac_src, wc_src, wc_res}
  // step = {ac_en, ac_inc, ac_dec, wc_en, wc_inc, wc_dec}
  localparam logic [6:0] LD_NONE   = 7'b0000000;
  localparam logic [6:0] LD_WC     = 7'b0101000;
  localparam logic [6:0] LD_ADDR   = 7'b1010000;
  localparam logic [6:0] LD_RE_CLR = 7'b0010101;
  localparam logic [6:0] LD_RE_REG = 7'b0011110;

  localparam logic [5:0] SP_NONE     = 6'b000000;
  localparam logic [5:0] SP_INC_DEC  = 6'b110101;
  localparam logic [5:0] SP_INC_INC  = 6'b110110;
  localparam logic [5:0] SP_DEC_INC  = 6'b101110;
  localparam logic [5:0] SP_INC_HOLD = 6'b110000;

  typedef struct {
    string       name;
    logic [20:0] expV;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int checks = 0;
  int errors = 0;

  am2940_ctrl #(.W(8)) dut (
    .clk    (clk),
    .res    (res),
    .ien    (ien),
    .instr  (instr),
    .di     (di),
    .wc_val (wcVal),
    .wr_val (wrVal),
    .cr     (cr),
    .ar_pl  (arPl),
    .wr_pl  (wrPl),
    .ac_pl  (acPl),
    .wc_pl  (wcPl),
    .ac_src (acSrc),
    .wc_src (wcSrc),
    .wc_res (wcRes),
    .ac_en  (acEn),
    .ac_inc (acInc),
    .ac_dec (acDec),
    .wc_en  (wcEn),
    .wc_inc (wcInc),
    .wc_dec (wcDec),
    .oe_sel (oeSel),
    .done   (done),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [20:0] mk(input logic [2:0] c, input logic [6:0] ld,
                                     input logic [5:0] sp, input logic [1:0] oe,
                                     input logic d, input logic b);
    return {c, ld, sp, oe, d, b};
  endfunction

  task automatic applyStimulus(input string name, input logic r, input logic e,
                               input logic [2:0] op, input logic [7:0] d,
                               input logic [7:0] wc, input logic [7:0] wr,
                               input logic [20:0] expV);
    sbEntry_t ent;
    @(posedge clk);
    #1;
    res   = r;
    ien   = e;
    instr = op;
    di    = d;
    wcVal = wc;
    wrVal = wr;
    ent.name = name;
    ent.expV = expV;
    sbQueue.push_back(ent);
  endtask

  task automatic checkOutput(input sbEntry_t ent);
    logic [20:0] act;
    act = {cr, arPl, wrPl, acPl, wcPl, acSrc, wcSrc, wcRes,
           acEn, acInc, acDec, wcEn, wcInc, wcDec, oeSel, done, busy};
    checks++;
    if (act !== ent.expV) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", ent.name, act, ent.expV);
    end
  endtask

  always @(negedge clk) begin
    if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res = 1'b1; ien = 1'b0; instr = 3'd0; di = 8'h00; wcVal = 8'h00; wrVal = 8'h00;
    #2 res = 1'b0;

    applyStimulus("reset_state",  1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b0));
    applyStimulus("nop_idle",     1'b1, 1'b0, 3'd7, 8'h00, 8'h00, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b0));
    applyStimulus("enable_idle",  1'b1, 1'b1, 3'd7, 8'h00, 8'h01, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b0));

    applyStimulus("m00_wrcr",     1'b1, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b0));
    applyStimulus("m00_ldwc",     1'b1, 1'b1, 3'd6, 8'h03, 8'h00, 8'h00, mk(3'b000, LD_WC, SP_NONE, 2'b00, 1'b0, 1'b0));
    applyStimulus("m00_en_wc3",   1'b1, 1'b1, 3'd7, 8'h00, 8'h03, 8'h03, mk(3'b000, LD_NONE, SP_INC_DEC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m00_en_wc2",   1'b1, 1'b1, 3'd7, 8'h00, 8'h02, 8'h03, mk(3'b000, LD_NONE, SP_INC_DEC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m00_en_wc1",   1'b1, 1'b1, 3'd7, 8'h00, 8'h01, 8'h03, mk(3'b000, LD_NONE, SP_INC_DEC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m00_en_done",  1'b1, 1'b1, 3'd7, 8'h00, 8'h00, 8'h03, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));

    applyStimulus("rst_ldwc",     1'b1, 1'b1, 3'd6, 8'h05, 8'h00, 8'h00, mk(3'b000, LD_WC, SP_NONE, 2'b00, 1'b1, 1'b0));
    applyStimulus("rst_en_armed", 1'b1, 1'b1, 3'd7, 8'h00, 8'h05, 8'h05, mk(3'b000, LD_NONE, SP_INC_DEC, 2'b00, 1'b0, 1'b1));
    applyStimulus("rst_mid",      1'b0, 1'b1, 3'd7, 8'h00, 8'h01, 8'h05, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b0));
    applyStimulus("rst_en_after", 1'b1, 1'b1, 3'd7, 8'h00, 8'h01, 8'h05, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b0));

    applyStimulus("m01_wrcr",     1'b1, 1'b1, 3'd0, 8'h01, 8'h00, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b0));
    applyStimulus("m01_ldwc",     1'b1, 1'b1, 3'd6, 8'h02, 8'h00, 8'h00, mk(3'b001, LD_WC, SP_NONE, 2'b00, 1'b0, 1'b0));
    applyStimulus("m01_reinit",   1'b1, 1'b1, 3'd4, 8'h00, 8'h02, 8'h02, mk(3'b001, LD_RE_CLR, SP_NONE, 2'b00, 1'b0, 1'b1));
    applyStimulus("m01_en_wc0",   1'b1, 1'b1, 3'd7, 8'h00, 8'h00, 8'h02, mk(3'b001, LD_NONE, SP_INC_INC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m01_en_wc1",   1'b1, 1'b1, 3'd7, 8'h00, 8'h01, 8'h02, mk(3'b001, LD_NONE, SP_INC_INC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m01_done",     1'b1, 1'b0, 3'd7, 8'h00, 8'h02, 8'h02, mk(3'b001, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));
    applyStimulus("m01z_ldwc",    1'b1, 1'b1, 3'd6, 8'h00, 8'h00, 8'h00, mk(3'b001, LD_WC, SP_NONE, 2'b00, 1'b1, 1'b0));
    applyStimulus("m01z_en_fe",   1'b1, 1'b1, 3'd7, 8'h00, 8'hfe, 8'h00, mk(3'b001, LD_NONE, SP_INC_INC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m01z_en_ff",   1'b1, 1'b1, 3'd7, 8'h00, 8'hff, 8'h00, mk(3'b001, LD_NONE, SP_INC_INC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m01z_done",    1'b1, 1'b0, 3'd7, 8'h00, 8'h00, 8'h00, mk(3'b001, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));

    applyStimulus("m10_wrcr",     1'b1, 1'b1, 3'd0, 8'h06, 8'h00, 8'h00, mk(3'b001, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));
    applyStimulus("m10_reinit",   1'b1, 1'b1, 3'd4, 8'h00, 8'h00, 8'h00, mk(3'b110, LD_RE_REG, SP_NONE, 2'b00, 1'b1, 1'b0));
    applyStimulus("m10_en_fe",    1'b1, 1'b1, 3'd7, 8'h00, 8'hfe, 8'h00, mk(3'b110, LD_NONE, SP_DEC_INC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m10_en_ff",    1'b1, 1'b1, 3'd7, 8'h00, 8'hff, 8'h00, mk(3'b110, LD_NONE, SP_DEC_INC, 2'b00, 1'b0, 1'b1));
    applyStimulus("m10_done",     1'b1, 1'b0, 3'd7, 8'h00, 8'h00, 8'h00, mk(3'b110, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));

    applyStimulus("m11_wrcr",     1'b1, 1'b1, 3'd0, 8'h03, 8'h00, 8'h00, mk(3'b110, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));
    applyStimulus("m11_ldwc",     1'b1, 1'b1, 3'd6, 8'h10, 8'h00, 8'h00, mk(3'b011, LD_WC, SP_NONE, 2'b00, 1'b1, 1'b0));
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("m11_en_%0d", i), 1'b1, 1'b1, 3'd7, 8'h00, 8'(i), 8'h10,
                    mk(3'b011, LD_NONE, SP_INC_HOLD, 2'b00, 1'b0, 1'b1));
    end
    applyStimulus("wrcr_armed",   1'b1, 1'b1, 3'd0, 8'h00, 8'h01, 8'h10, mk(3'b011, LD_NONE, SP_NONE, 2'b00, 1'b0, 1'b1));
    applyStimulus("new_mode_en",  1'b1, 1'b1, 3'd7, 8'h00, 8'h01, 8'h10, mk(3'b000, LD_NONE, SP_INC_DEC, 2'b00, 1'b0, 1'b1));
    applyStimulus("new_mode_dn",  1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h10, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));

    applyStimulus("rdcr",         1'b1, 1'b1, 3'd1, 8'h00, 8'h00, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b01, 1'b1, 1'b0));
    applyStimulus("rdwc",         1'b1, 1'b1, 3'd2, 8'h00, 8'h00, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b10, 1'b1, 1'b0));
    applyStimulus("rdac",         1'b1, 1'b1, 3'd3, 8'h00, 8'h00, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b11, 1'b1, 1'b0));
    applyStimulus("ldaddr",       1'b1, 1'b1, 3'd5, 8'h5a, 8'h00, 8'h00, mk(3'b000, LD_ADDR, SP_NONE, 2'b00, 1'b1, 1'b0));
    applyStimulus("nop_enable",   1'b1, 1'b0, 3'd7, 8'h00, 8'h01, 8'h00, mk(3'b000, LD_NONE, SP_NONE, 2'b00, 1'b1, 1'b0));

    for (int i = 0; i < 10 && sbQueue.size() > 0; i++) @(negedge clk);
    #1;
    if (sbQueue.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbQueue.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
